// File: rtl/cobs_pkg.sv
// Shared types and constants for the COBS frame loader.
package cobs_pkg;

    // Decoder position within a COBS frame
    typedef enum logic [1:0] {
        IDLE,   // waiting for the first code byte of a frame
        BLOCK,  // copying the data bytes of the current block
        CODE    // expecting the next code byte or the frame delimiter
    } state_t;

    localparam logic [7:0] COBS_DELIM    = 8'h00;
    localparam logic [7:0] COBS_MAX_CODE = 8'hFF;

endpackage

// File: rtl/cobs_load_ctrl.sv
// COBS frame loader: decodes a 0x00-delimited COBS byte stream from the UART
// receiver into sequential byte writes starting at BASE_ADDR, and holds the
// core in reset until a complete frame has been loaded.
// Optional build macro: COBS_SUM_CHECK_EN -- reject frames whose 8-bit sum of
// decoded bytes is non-zero (last payload byte is a two's-complement checksum).
module cobs_load_ctrl
    import cobs_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              core_reset,
    output logic              frame_done,
    output logic              frame_err,
    output logic [ADDR_W:0]   frame_len
);

    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state;
    logic [7:0]      code;
    logic [7:0]      block_cnt;
    logic            pending_zero;
    logic [ADDR_W:0] wr_cnt;

    // Every address has been written once; one more write would wrap
    logic            addr_full;
    // Properties of rx_data when it is taken as a new code byte
    logic            code_has_data;
    logic            code_adds_zero;
    logic [7:0]      code_block_cnt;
    logic            sum_ok;

    assign addr_full      = wr_cnt[ADDR_W];
    assign code_has_data  = (rx_data != 8'h01);
    assign code_adds_zero = (rx_data != COBS_MAX_CODE);
    assign code_block_cnt = rx_data - 8'h01;

`ifdef COBS_SUM_CHECK_EN
    logic [7:0] sum;
    assign sum_ok = (sum == 8'h00);
`else
    assign sum_ok = 1'b1;
`endif

`ifdef COBS_SUM_CHECK_EN
    // Running 8-bit sum of decoded data bytes; inserted zeros add nothing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum <= 8'h00;
        end else if (rx_valid) begin
            if (state == IDLE) begin
                sum <= 8'h00;
            end else if (state == BLOCK && rx_data != COBS_DELIM && !addr_full) begin
                sum <= sum + rx_data;
            end
        end
    end
`endif

    // Frame decoder: consumes one byte per rx_valid and produces registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            code         <= 8'h00;
            block_cnt    <= 8'h00;
            pending_zero <= 1'b0;
            wr_cnt       <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= 8'h00;
            core_reset   <= 1'b1;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
            frame_len    <= '0;
        end else begin
            // NOTE: strobes default low every cycle and are raised below only
            // when needed; non-blocking assignments let the later one win.
            mem_we     <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            if (rx_valid) begin
                unique case (state)
                    IDLE: begin
                        // A delimiter here is an empty frame and is ignored
                        if (rx_data != COBS_DELIM) begin
                            code         <= rx_data;
                            block_cnt    <= code_block_cnt;
                            pending_zero <= code_has_data ? 1'b0 : code_adds_zero;
                            wr_cnt       <= '0;
                            core_reset   <= 1'b1;
                            state        <= code_has_data ? BLOCK : CODE;
                        end
                    end

                    BLOCK: begin
                        if (rx_data == COBS_DELIM || addr_full) begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            mem_we    <= 1'b1;
                            mem_addr  <= BASE_ADDR + wr_cnt[ADDR_W-1:0];
                            mem_wdata <= rx_data;
                            wr_cnt    <= wr_cnt + CNT_ONE;
                            block_cnt <= block_cnt - 8'h01;
                            if (block_cnt == 8'h01) begin
                                pending_zero <= (code != COBS_MAX_CODE);
                                state        <= CODE;
                            end
                        end
                    end

                    CODE: begin
                        if (rx_data == COBS_DELIM) begin
                            // The zero implied by the last block is not part of the payload
                            if (sum_ok) begin
                                frame_done <= 1'b1;
                                frame_len  <= wr_cnt;
                                core_reset <= 1'b0;
                            end else begin
                                frame_err  <= 1'b1;
                            end
                            state <= IDLE;
                        end else if (pending_zero && addr_full) begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            if (pending_zero) begin
                                mem_we    <= 1'b1;
                                mem_addr  <= BASE_ADDR + wr_cnt[ADDR_W-1:0];
                                mem_wdata <= COBS_DELIM;
                                wr_cnt    <= wr_cnt + CNT_ONE;
                            end
                            code         <= rx_data;
                            block_cnt    <= code_block_cnt;
                            pending_zero <= code_has_data ? 1'b0 : code_adds_zero;
                            state        <= code_has_data ? BLOCK : CODE;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cobs_load_ctrl.sv
// Directed testbench for cobs_load_ctrl. Two instances share the byte stream:
// dut_a (ADDR_W=16, BASE_ADDR=0) and dut_b (ADDR_W=4, BASE_ADDR=3) for wrap.
module tb_cobs_load_ctrl;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;

    logic        mem_we_a, core_reset_a, frame_done_a, frame_err_a;
    logic [15:0] mem_addr_a;
    logic [7:0]  mem_wdata_a;
    logic [16:0] frame_len_a;

    logic        mem_we_b, core_reset_b, frame_done_b, frame_err_b;
    logic [3:0]  mem_addr_b;
    logic [7:0]  mem_wdata_b;
    logic [4:0]  frame_len_b;

    int checks = 0;
    int errors = 0;

    // Write logs and pulse counters gathered after every clock step
    logic [15:0] wa_addr[$];
    logic [7:0]  wa_data[$];
    logic [3:0]  wb_addr[$];
    logic [7:0]  wb_data[$];
    int done_a, err_a, done_b, err_b;

    cobs_load_ctrl #(.ADDR_W(16), .BASE_ADDR(16'h0000)) dut_a (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .core_reset(core_reset_a), .frame_done(frame_done_a),
        .frame_err(frame_err_a), .frame_len(frame_len_a)
    );

    cobs_load_ctrl #(.ADDR_W(4), .BASE_ADDR(4'h3)) dut_b (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .core_reset(core_reset_b), .frame_done(frame_done_b),
        .frame_err(frame_err_b), .frame_len(frame_len_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_log();
        wa_addr.delete(); wa_data.delete();
        wb_addr.delete(); wb_data.delete();
        done_a = 0; err_a = 0; done_b = 0; err_b = 0;
    endtask

    // One clock cycle, optionally presenting a byte; outputs sampled 1 after the edge
    task automatic step(input logic valid, input logic [7:0] b);
        @(negedge clk);
        rx_valid = valid;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        if (mem_we_a) begin wa_addr.push_back(mem_addr_a); wa_data.push_back(mem_wdata_a); end
        if (mem_we_b) begin wb_addr.push_back(mem_addr_b); wb_data.push_back(mem_wdata_b); end
        done_a += int'(frame_done_a); err_a += int'(frame_err_a);
        done_b += int'(frame_done_b); err_b += int'(frame_err_b);
        checks++;
        if (frame_done_a === 1'b1 && frame_err_a === 1'b1) begin
            errors++; $display("FAIL pulse_exclusive_a: done and err both high");
        end
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        #3;
        checks++; if (mem_we_a !== 1'b0)      begin errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we_a); end
        checks++; if (mem_addr_a !== 16'h0)   begin errors++; $display("FAIL rst_mem_addr: got %h want 0000", mem_addr_a); end
        checks++; if (mem_wdata_a !== 8'h0)   begin errors++; $display("FAIL rst_mem_wdata: got %h want 00", mem_wdata_a); end
        checks++; if (core_reset_a !== 1'b1)  begin errors++; $display("FAIL rst_core_reset: got %b want 1", core_reset_a); end
        checks++; if (frame_done_a !== 1'b0)  begin errors++; $display("FAIL rst_frame_done: got %b want 0", frame_done_a); end
        checks++; if (frame_err_a !== 1'b0)   begin errors++; $display("FAIL rst_frame_err: got %b want 0", frame_err_a); end
        checks++; if (frame_len_a !== 17'h0)  begin errors++; $display("FAIL rst_frame_len: got %h want 0", frame_len_a); end
        checks++; if (mem_addr_b !== 4'h3)    begin errors++; $display("FAIL rst_mem_addr_b: got %h want 3", mem_addr_b); end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic_frame();
        logic [7:0]  exp_d[4];
        logic [15:0] exp_a[4];
        exp_d = '{8'h11, 8'h22, 8'h00, 8'h33};
        exp_a = '{16'd0, 16'd1, 16'd2, 16'd3};
        clear_log();
        send(8'h03); send(8'h11); send(8'h22); send(8'h02); send(8'h33);
        checks++; if (done_a != 0 || core_reset_a !== 1'b1) begin
            errors++; $display("FAIL basic_pre_delim: done=%0d core_reset=%b want 0/1", done_a, core_reset_a);
        end
        send(8'h00);
        checks++; if (frame_done_a !== 1'b1) begin errors++; $display("FAIL basic_done_pulse: got %b want 1", frame_done_a); end
        checks++; if (frame_len_a !== 17'd4) begin errors++; $display("FAIL basic_frame_len: got %0d want 4", frame_len_a); end
        checks++; if (core_reset_a !== 1'b0) begin errors++; $display("FAIL basic_core_reset: got %b want 0", core_reset_a); end
        checks++; if (wa_addr.size() != 4)   begin errors++; $display("FAIL basic_write_count: got %0d want 4", wa_addr.size()); end
        for (int i = 0; i < 4 && i < wa_addr.size(); i++) begin
            checks++;
            if (wa_addr[i] !== exp_a[i] || wa_data[i] !== exp_d[i]) begin
                errors++; $display("FAIL basic_write%0d: got %h@%0d want %h@%0d", i, wa_data[i], wa_addr[i], exp_d[i], exp_a[i]);
            end
        end
        step(1'b0, 8'h00);
        checks++; if (frame_done_a !== 1'b0 || done_a != 1) begin
            errors++; $display("FAIL basic_done_one_cycle: done=%b count=%0d want 0/1", frame_done_a, done_a);
        end
    endtask

    task automatic test_full_block();
        int bad;
        clear_log();
        send(8'hFF);
        for (int i = 1; i <= 254; i++) send(8'(i));
        send(8'h01); send(8'h00);
        checks++; if (wa_addr.size() != 254) begin errors++; $display("FAIL ff_write_count: got %0d want 254", wa_addr.size()); end
        bad = 0;
        for (int i = 0; i < wa_addr.size() && i < 254; i++)
            if (wa_addr[i] !== 16'(i) || wa_data[i] !== 8'(i + 1)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL ff_write_data: got %0d bad writes want 0", bad); end
        checks++; if (done_a != 1 || err_a != 0) begin errors++; $display("FAIL ff_pulses: done=%0d err=%0d want 1/0", done_a, err_a); end
        checks++; if (frame_len_a !== 17'd254) begin errors++; $display("FAIL ff_frame_len: got %0d want 254", frame_len_a); end
    endtask

    task automatic test_early_delim();
        clear_log();
        send(8'h04); send(8'hAA); send(8'hBB); send(8'h00);
        checks++; if (frame_err_a !== 1'b1) begin errors++; $display("FAIL early_err_pulse: got %b want 1", frame_err_a); end
        checks++; if (done_a != 0 || err_a != 1) begin errors++; $display("FAIL early_pulses: done=%0d err=%0d want 0/1", done_a, err_a); end
        checks++; if (core_reset_a !== 1'b1) begin errors++; $display("FAIL early_core_reset: got %b want 1", core_reset_a); end
        checks++; if (frame_len_a !== 17'd254) begin errors++; $display("FAIL early_len_kept: got %0d want 254", frame_len_a); end
        checks++; if (wa_addr.size() != 2 || wa_data[0] !== 8'hAA || wa_addr[1] !== 16'd1 || wa_data[1] !== 8'hBB) begin
            errors++; $display("FAIL early_writes: got %0d writes want AA@0 BB@1", wa_addr.size());
        end
        clear_log();
        send(8'h02); send(8'h55); send(8'h00);
        checks++; if (wa_addr.size() != 1 || wa_addr[0] !== 16'd0 || wa_data[0] !== 8'h55) begin
            errors++; $display("FAIL recover_write: got %0d writes want 55@0", wa_addr.size());
        end
        checks++; if (done_a != 1 || frame_len_a !== 17'd1 || core_reset_a !== 1'b0) begin
            errors++; $display("FAIL recover_done: done=%0d len=%0d core_reset=%b want 1/1/0", done_a, frame_len_a, core_reset_a);
        end
    endtask

    task automatic test_idle_zeros();
        clear_log();
        send(8'h00); send(8'h00);
        checks++; if (wa_addr.size() != 0 || done_a != 0 || err_a != 0) begin
            errors++; $display("FAIL idle_zeros: writes=%0d done=%0d err=%0d want 0/0/0", wa_addr.size(), done_a, err_a);
        end
        checks++; if (core_reset_a !== 1'b0) begin errors++; $display("FAIL idle_core_reset: got %b want 0", core_reset_a); end
    endtask

    task automatic test_reset_mid_frame();
        clear_log();
        send(8'h03); send(8'h11);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (core_reset_a !== 1'b1 || frame_len_a !== 17'd0 || mem_addr_a !== 16'd0 || mem_we_a !== 1'b0 || mem_wdata_a !== 8'h00) begin
            errors++; $display("FAIL midrst_outputs: core_reset=%b len=%0d addr=%h we=%b wdata=%h want 1/0/0/0/00",
                               core_reset_a, frame_len_a, mem_addr_a, mem_we_a, mem_wdata_a);
        end
        @(negedge clk);
        reset = 1'b0;
        clear_log();
        send(8'h02); send(8'h77); send(8'h00);
        checks++; if (wa_addr.size() != 1 || wa_addr[0] !== 16'd0 || wa_data[0] !== 8'h77) begin
            errors++; $display("FAIL midrst_write: got %0d writes want 77@0", wa_addr.size());
        end
        checks++; if (done_a != 1 || frame_len_a !== 17'd1) begin
            errors++; $display("FAIL midrst_done: done=%0d len=%0d want 1/1", done_a, frame_len_a);
        end
    endtask

    task automatic test_sum_check();
`ifdef COBS_SUM_CHECK_EN
        clear_log();
        send(8'h03); send(8'h10); send(8'hF0); send(8'h00);
        checks++; if (done_a != 1 || err_a != 0 || frame_len_a !== 17'd2) begin
            errors++; $display("FAIL sum_good: done=%0d err=%0d len=%0d want 1/0/2", done_a, err_a, frame_len_a);
        end
        clear_log();
        send(8'h03); send(8'h10); send(8'hF1); send(8'h00);
        checks++; if (done_a != 0 || err_a != 1 || core_reset_a !== 1'b1 || frame_len_a !== 17'd2) begin
            errors++; $display("FAIL sum_bad: done=%0d err=%0d core_reset=%b len=%0d want 0/1/1/2", done_a, err_a, core_reset_a, frame_len_a);
        end
        checks++; if (wa_addr.size() != 2 || wa_data[1] !== 8'hF1) begin
            errors++; $display("FAIL sum_bad_writes: got %0d writes want 2 ending F1", wa_addr.size());
        end
`else
        clear_log();
        send(8'h03); send(8'h10); send(8'hF1); send(8'h00);
        checks++; if (done_a != 1 || err_a != 0 || frame_len_a !== 17'd2 || core_reset_a !== 1'b0) begin
            errors++; $display("FAIL nosum_done: done=%0d err=%0d len=%0d core_reset=%b want 1/0/2/0", done_a, err_a, frame_len_a, core_reset_a);
        end
        checks++; if (wa_addr.size() != 2 || wa_data[1] !== 8'hF1) begin
            errors++; $display("FAIL nosum_writes: got %0d writes want 2 ending F1", wa_addr.size());
        end
`endif
    endtask

    task automatic test_overflow();
        int bad;
        do_reset();
        clear_log();
        send(8'h12);
        for (int i = 0; i < 17; i++) send(8'(8'h80 + i));
        checks++; if (wb_addr.size() != 16) begin errors++; $display("FAIL ovf_write_count: got %0d want 16", wb_addr.size()); end
        bad = 0;
        for (int i = 0; i < wb_addr.size() && i < 16; i++)
            if (wb_addr[i] !== 4'(3 + i) || wb_data[i] !== 8'(8'h80 + i)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL ovf_write_data: got %0d bad writes want 0", bad); end
        checks++; if (frame_err_b !== 1'b1 || err_b != 1 || done_b != 0) begin
            errors++; $display("FAIL ovf_err: pulse=%b err=%0d done=%0d want 1/1/0", frame_err_b, err_b, done_b);
        end
        checks++; if (core_reset_b !== 1'b1 || frame_len_b !== 5'd0) begin
            errors++; $display("FAIL ovf_state: core_reset=%b len=%0d want 1/0", core_reset_b, frame_len_b);
        end
        send(8'h00);
        checks++; if (done_b != 0 || wb_addr.size() != 16) begin
            errors++; $display("FAIL ovf_trailing_delim: done=%0d writes=%0d want 0/16", done_b, wb_addr.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_full_block();
        test_early_delim();
        test_idle_zeros();
        test_reset_mid_frame();
        test_sum_check();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cobs_load_ctrl.md
Name: cobs_load_ctrl

Overview:
Sequencer between the UART receiver and the instruction/data memory write port on the FPGA top.
- Consumes the received byte stream and decodes COBS frames (0x00-delimited).
- Writes each decoded byte to consecutive memory addresses from BASE_ADDR.
- Holds the core in reset until a complete, valid frame has been loaded.

Parameters:
ADDR_W, 16, width of memory byte address
BASE_ADDR, 0, address of first decoded byte of every frame

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_valid  in  1  single-cycle strobe, rx_data valid; no backpressure to UART
rx_data  in  8  received byte
mem_we  out  1  byte write strobe, one cycle per decoded byte
mem_addr  out  ADDR_W  write address
mem_wdata  out  8  decoded byte
core_reset  out  1  hold core in reset
frame_done  out  1  one-cycle pulse, valid frame loaded
frame_err  out  1  one-cycle pulse, frame aborted
frame_len  out  ADDR_W+1  decoded byte count of last valid frame

Behaviour:
- Reset values:
  - mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - core_reset=1, frame_done=0, frame_err=0, frame_len=0.
  - FSM=IDLE, block_cnt=0, pending_zero=0, wr_cnt=0.
- All outputs are registered. mem_we/mem_wdata/mem_addr appear the cycle after the causing rx_valid, so at most one write per input byte.
- States:
  - IDLE: awaiting first code byte.
    - rx_data==0x00: ignored (empty frame, no pulse).
    - Else: code=rx_data, block_cnt=code-1, pending_zero=0, wr_cnt=0, core_reset<=1; go to BLOCK if block_cnt>0, else to CODE with pending_zero=(code!=0xFF).
  - BLOCK: each rx_valid byte.
    - rx_data==0x00 while block_cnt>0: frame_err pulse, go to IDLE; core_reset stays 1.
    - Else: write rx_data at BASE_ADDR+wr_cnt, wr_cnt++, block_cnt--.
    - When block_cnt reaches 0: go to CODE, pending_zero=(code!=0xFF).
  - CODE: each rx_valid byte.
    - rx_data==0x00: end of frame, pending zero dropped. frame_done pulse, frame_len=wr_cnt, core_reset<=0 in the same cycle as frame_done, go to IDLE.
    - Else: if pending_zero, write 0x00 at the current address and wr_cnt++. Then load the new code byte exactly as in IDLE, without touching wr_cnt or core_reset.
- Overflow: a write that would occur with wr_cnt==2^ADDR_W (address wrap) is suppressed; frame_err pulse, go to IDLE.
- frame_done and frame_err are mutually exclusive and never assert in the same cycle.
- After frame_err: core_reset remains 1 until the next valid frame; frame_len keeps its previous value.
- rx_valid low: no state change. No other requester drives mem_*.
- Asynchronous reset mid-frame: all state returns to reset values immediately; the partial frame is discarded and core_reset=1.

Optional Feature:
COBS_SUM_CHECK_EN
- Defined: tracks an 8-bit running sum of all decoded bytes, including inserted zeros. At the terminating delimiter, sum!=0 gives a frame_err pulse instead of frame_done; core_reset stays 1 and frame_len is unchanged. The last payload byte is the two's-complement checksum and is still written to memory.
- Undefined: no sum logic; every correctly terminated frame gives frame_done.

Decomposition:
- Package cobs_pkg holds:
  - state_t enum {IDLE, BLOCK, CODE}
  - COBS_DELIM=8'h00
  - COBS_MAX_CODE=8'hFF
- Single module; no sub-module is warranted. The top instantiates it between the UART RX and the memory write port.

Test Plan:
- Frame 03 11 22 02 33 00 -> writes 11@0, 22@1, 00@2, 33@3; frame_done one cycle after the final 00; frame_len=4; core_reset 1->0.
- Code FF + 254 bytes 01..FE, then 01 00 -> 254 writes at 0..253, no inserted zero, frame_len=254.
- 04 AA BB 00 (early delimiter) -> writes AA@0, BB@1, frame_err pulse, no frame_done, core_reset stays 1. A following 02 55 00 -> 55@0, frame_done, frame_len=1.
- Bytes 00 00 in IDLE -> no writes, no pulses, core_reset unchanged. Reset asserted after 03 11 -> outputs return to reset values; next frame 02 77 00 writes 77@BASE_ADDR.
- COBS_SUM_CHECK_EN: 03 10 F0 00 -> frame_done. 03 10 F1 00 -> frame_err, core_reset=1.
- ADDR_W=4 with a 17-byte payload -> 16 writes, then frame_err on the 17th byte.
